// File: rtl/pixel_scan_generator_pkg.sv
// Shared types and constants for the raster-scan pixel source feeding the ray pipeline.
// Coordinates use Q11.21 fixed point: integer part in [31:21], fraction in [20:0].
package pixel_scan_generator_pkg;

  typedef logic [31:0] fp;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int FP_FRAC_BITS  = 21;
  localparam int SCAN_CREDITS  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  function automatic fp int_to_fp_Q11_21(input logic [10:0] value);
    return {value, {FP_FRAC_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/pixel_scan_generator_credit_counter.sv
// Saturating up/down credit counter: returns add, issues subtract, both together cancel.
// A return while already full is dropped rather than overflowing.
module credit_counter
  import pixel_scan_generator_pkg::*;
#(
  parameter int CREDITS = SCAN_CREDITS,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full;
  logic          empty;

  assign full  = (count_q == CW'(CREDITS));
  assign empty = (count_q == '0);

  always_comb begin
    count_d = count_q;
    case ({inc_i, dec_i})
      2'b10: if (!full) count_d = count_q + 1'b1;
      2'b01: if (!empty) count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= CW'(CREDITS);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign empty_o = empty;
  assign full_o  = full;

endmodule

// File: rtl/pixel_scan_generator.sv
// Credit-throttled raster scan source emitting one Q11.21 pixel coordinate per cycle.
// Define FRAME_LOOP_EN to rescan frames back to back without a start pulse.
module pixel_scan_generator
  import pixel_scan_generator_pkg::*;
#(
  parameter int H_RES   = SCREEN_WIDTH,
  parameter int V_RES   = SCREEN_HEIGHT,
  parameter int CREDITS = SCAN_CREDITS,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          enable,
  input  logic          credit_return,
  output logic [31:0]   screen_x,
  output logic [31:0]   screen_y,
  output logic          valid_out,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic          busy,
  output logic          frame_done,
  output logic [CW-1:0] credits_avail
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  scan_state_t   state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  fp             screen_x_q;
  fp             screen_y_q;
  logic          valid_q;
  logic          sof_q;
  logic          eol_q;
  logic          eof_q;
  logic          busy_q;
  logic          frame_done_q;

  logic [CW-1:0] credit_count;
  logic          credit_empty;
  logic          credit_full;
  logic          issue;
  logic          last_x;
  logic          last_y;
  logic          drain_done;

  // A credit returned this very cycle can be spent immediately.
  assign issue  = (state_q == RUN) && enable && (!credit_empty || credit_return);
  assign last_x = (x_q == XW'(H_RES - 1));
  assign last_y = (y_q == YW'(V_RES - 1));

  // Leave DRAIN on the edge where the count becomes full, including a return arriving now.
  assign drain_done = credit_full || ((credit_count == CW'(CREDITS - 1)) && credit_return);

  credit_counter #(
    .CREDITS (CREDITS),
    .CW      (CW)
  ) u_credit_counter (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (credit_return),
    .dec_i   (issue),
    .count_o (credit_count),
    .empty_o (credit_empty),
    .full_o  (credit_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      screen_x_q   <= '0;
      screen_y_q   <= '0;
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            screen_x_q <= int_to_fp_Q11_21(11'(x_q));
            screen_y_q <= int_to_fp_Q11_21(11'(y_q));
            valid_q    <= 1'b1;
            sof_q      <= (x_q == '0) && (y_q == '0);
            eol_q      <= last_x;
            eof_q      <= last_x && last_y;
            // The final pixel parks the counters; the next frame clears them on entry to RUN.
            if (!last_x) begin
              x_q <= x_q + 1'b1;
            end else if (!last_y) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        DONE: begin
`ifdef FRAME_LOOP_EN
          state_q <= RUN;
          x_q     <= '0;
          y_q     <= '0;
          busy_q  <= 1'b1;
`else
          state_q <= IDLE;
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign screen_x      = screen_x_q;
  assign screen_y      = screen_y_q;
  assign valid_out     = valid_q;
  assign sof           = sof_q;
  assign eol           = eol_q;
  assign eof           = eof_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign credits_avail = credit_count;

endmodule
